// File: rtl/os_burst_generator.sv
// Ordered-set burst generator: streams TS1/TS2/EIOS/SKP sets on all active lanes and inserts SKPs on beat-count intervals.
// First beat two cycles after start; all outputs registered; beats hold while tready is low and never stall back-to-back sets.
module os_burst_generator #(
    parameter int MAX_NUM_LANES = 4,
    parameter int USER_WIDTH    = 4,
    parameter int SKP_INTERVAL  = 370,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic [1:0]                           os_type_i,
    input  logic [CNT_WIDTH-1:0]                 repeat_cnt_i,
    input  logic [127:0]                         ts_template_i,
    input  logic                                 set_lane_i,
    input  logic [MAX_NUM_LANES-1:0]             lane_active_i,
    input  logic                                 abort_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [CNT_WIDTH-1:0]                 os_count_o,
    output logic [32*MAX_NUM_LANES-1:0]          m_axis_tdata,
    output logic [4*MAX_NUM_LANES-1:0]           m_axis_tkeep,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    output logic [USER_WIDTH*MAX_NUM_LANES-1:0]  m_axis_tuser,
    input  logic                                 m_axis_tready
);

    localparam logic [1:0] OS_EIOS = 2'd2;
    localparam logic [1:0] OS_SKP  = 2'd3;
    localparam int BCW = (SKP_INTERVAL < 1) ? 1 : $clog2(SKP_INTERVAL + 1);
    localparam logic [BCW-1:0] SKP_LIM = BCW'(SKP_INTERVAL);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_SKP, ST_DONE} state_t;

    state_t                              r_state, w_state_nxt;
    logic [1:0]                          r_os_type;
    logic [CNT_WIDTH-1:0]                r_repeat;
    logic [127:0]                        r_template;
    logic                                r_set_lane;
    logic [MAX_NUM_LANES-1:0]            r_lane_active;
    logic                                r_abort;
    logic [BCW-1:0]                      r_beat_cnt;
    logic [CNT_WIDTH-1:0]                r_os_count;
    logic [1:0]                          r_beat;
    logic                                r_out_skp;
    logic                                r_tvalid, r_tlast, r_busy, r_done;
    logic [32*MAX_NUM_LANES-1:0]         r_tdata;
    logic [4*MAX_NUM_LANES-1:0]          r_tkeep;
    logic [USER_WIDTH*MAX_NUM_LANES-1:0] r_tuser;

    logic                                w_acc, w_abort, w_skp_due, w_fin, w_os_inc, w_tlast_nxt;
    logic [BCW-1:0]                      w_beat_cnt_inc;
    logic [CNT_WIDTH-1:0]                w_os_count_inc;
    logic [1:0]                          w_last_idx;
    logic                                w_issue, w_issue_skp, w_drop;
    logic [1:0]                          w_issue_beat;
    logic [8:0]                          w_sym;
    logic [3:0]                          w_kf;
    logic [32*MAX_NUM_LANES-1:0]         w_beat_dat;
    logic [4*MAX_NUM_LANES-1:0]          w_beat_keep;
    logic [USER_WIDTH*MAX_NUM_LANES-1:0] w_beat_user;

    assign w_acc          = r_tvalid & m_axis_tready;
    assign w_abort        = r_abort | abort_i;
    assign w_beat_cnt_inc = (SKP_INTERVAL != 0 && r_beat_cnt < SKP_LIM) ? r_beat_cnt + BCW'(1) : r_beat_cnt;
    assign w_skp_due      = (SKP_INTERVAL != 0) && (w_beat_cnt_inc >= SKP_LIM);
    assign w_os_count_inc = r_os_count + CNT_WIDTH'(1);
    assign w_fin          = ((r_repeat != '0) && (w_os_count_inc == r_repeat)) || w_abort;
    assign w_last_idx     = (r_os_type == OS_EIOS) ? 2'd0 : 2'd3;
    assign w_os_inc       = w_acc && r_tlast &&
                            (r_state == ST_SEND || (r_state == ST_SKP && r_os_type == OS_SKP));
    assign w_tlast_nxt    = w_issue_skp || (w_issue_beat == w_last_idx);

    // {K flag, byte} for symbol s of the set currently being built on a given lane
    function automatic logic [8:0] sym_at(input logic skp, input logic [3:0] s, input logic [7:0] lane);
        logic [8:0] r;
        r = {1'b0, r_template[8*s +: 8]};
        if (skp)
            r = (s[1:0] == 2'd0) ? {1'b1, 8'hBC} : {1'b1, 8'h1C};
        else if (r_os_type == OS_EIOS)
            r = (s[1:0] == 2'd0) ? {1'b1, 8'hBC} : {1'b1, 8'h7C};
        else if (s == 4'd0)
            r = {1'b1, 8'hBC};
        else if (s == 4'd2)
            r = r_set_lane ? {1'b0, lane} : {1'b1, 8'hF7};
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_issue_skp  = 1'b0;
        w_issue_beat = 2'd0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: if (start_i) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (abort_i) begin
                    w_state_nxt = ST_DONE;
                end else if (r_os_type == OS_SKP) begin
                    w_state_nxt = ST_SKP;
                    w_issue     = 1'b1;
                    w_issue_skp = 1'b1;
                end else begin
                    w_state_nxt = ST_SEND;
                    w_issue     = 1'b1;
                end
            end
            ST_SEND: if (w_acc) begin
                if (!r_tlast) begin
                    w_issue      = 1'b1;
                    w_issue_beat = r_beat + 2'd1;
                end else if (w_fin) begin
                    w_state_nxt = ST_DONE;
                    w_drop      = 1'b1;
                end else if (w_skp_due) begin
                    w_state_nxt = ST_SKP;
                    w_issue     = 1'b1;
                    w_issue_skp = 1'b1;
                end else begin
                    w_issue = 1'b1;
                end
            end
            ST_SKP: if (w_acc) begin
                // inserted SKPs only end the burst on abort; SKP-only bursts count them
                if ((r_os_type == OS_SKP) ? w_fin : w_abort) begin
                    w_state_nxt = ST_DONE;
                    w_drop      = 1'b1;
                end else if (r_os_type == OS_SKP) begin
                    w_issue     = 1'b1;
                    w_issue_skp = 1'b1;
                end else begin
                    w_state_nxt = ST_SEND;
                    w_issue     = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_beat_dat  = '0;
        w_beat_keep = '0;
        w_beat_user = '0;
        w_sym       = '0;
        w_kf        = '0;
        for (int i = 0; i < MAX_NUM_LANES; i++) begin
            if (r_lane_active[i]) begin
                for (int k = 0; k < 4; k++) begin
                    w_sym = sym_at(w_issue_skp, {w_issue_beat, 2'(k)}, 8'(i));
                    w_beat_dat[32*i+8*k +: 8] = w_sym[7:0];
                    w_kf[k] = w_sym[8];
                end
                w_beat_keep[4*i +: 4] = 4'hF;
                w_beat_user[USER_WIDTH*i +: USER_WIDTH] = USER_WIDTH'(w_kf);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_os_type     <= '0;
            r_repeat      <= '0;
            r_template    <= '0;
            r_set_lane    <= 1'b0;
            r_lane_active <= '0;
            r_abort       <= 1'b0;
            r_beat_cnt    <= '0;
            r_os_count    <= '0;
            r_beat        <= '0;
            r_out_skp     <= 1'b0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tdata       <= '0;
            r_tkeep       <= '0;
            r_tuser       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start_i) begin
                r_os_type     <= os_type_i;
                r_repeat      <= repeat_cnt_i;
                r_template    <= ts_template_i;
                r_set_lane    <= set_lane_i;
                r_lane_active <= lane_active_i;
            end
            if (r_state == ST_IDLE || r_state == ST_DONE) r_abort <= 1'b0;
            else if (abort_i)                             r_abort <= 1'b1;
            if (r_state == ST_LOAD) r_os_count <= '0;
            else if (w_os_inc)      r_os_count <= w_os_count_inc;
            if (w_acc) r_beat_cnt <= r_out_skp ? '0 : w_beat_cnt_inc;
            if (w_issue) begin
                r_tvalid  <= 1'b1;
                r_tlast   <= w_tlast_nxt;
                r_tdata   <= w_beat_dat;
                r_tkeep   <= w_beat_keep;
                r_tuser   <= w_beat_user;
                r_out_skp <= w_issue_skp;
                r_beat    <= w_issue_beat;
            end else if (w_drop) begin
                r_tvalid  <= 1'b0;
                r_tlast   <= 1'b0;
                r_tdata   <= '0;
                r_tkeep   <= '0;
                r_tuser   <= '0;
                r_out_skp <= 1'b0;
            end
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign os_count_o    = r_os_count;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;

endmodule
